// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first serial receiver; define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (BAUD_DIVIDER >= 8)
module uart_rx #(
   parameter int BAUD_DIVIDER = 104
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Rx,
   output logic [7:0] O_DATA,
   output logic       NrD,
   output logic       RiP,
   output logic       FrE
);
   localparam int TW = $clog2(BAUD_DIVIDER);
   localparam logic [TW-1:0] HALF = TW'(BAUD_DIVIDER / 2 - 1);
   localparam logic [TW-1:0] FULL = TW'(BAUD_DIVIDER - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
   state_t state, state_nx;
   logic s1, rx_s, rx_d, fall, tick, smp, stop_ok;
   logic [TW-1:0] timer;
   logic [2:0] cnt;
   logic [7:0] shreg;
   assign fall = rx_d & ~rx_s;
`ifdef UART_RX_MAJORITY_EN
   logic m0, m1, pend;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m0 <= 1'b1;
         m1 <= 1'b1;
         pend <= 1'b0;
      end else begin
         if (timer == TW'(1)) m0 <= rx_s;
         if (timer == '0) m1 <= rx_s;
         pend <= timer == '0 && state inside {START, DATA, STOP};
      end
   assign tick = pend;
   assign smp = (m0 & m1) | (m0 & rx_s) | (m1 & rx_s);
`else
   assign tick = timer == '0 && state inside {START, DATA, STOP};
   assign smp = rx_s;
`endif
   assign stop_ok = state == STOP && tick && smp;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      RiP = state != IDLE;
      case (state)
         IDLE:  state_nx = fall ? START : IDLE;
         START: state_nx = tick ? (smp ? IDLE : DATA) : START;
         DATA:  state_nx = (tick && cnt == 3'd7) ? STOP : DATA;
         STOP:  state_nx = tick ? (smp ? IDLE : BRK) : STOP;
         BRK:   state_nx = rx_s ? IDLE : BRK;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
         timer <= '0;
         cnt <= '0;
         shreg <= '0;
         O_DATA <= '0;
         NrD <= 1'b0;
         FrE <= 1'b0;
      end else begin
         s1 <= Rx;
         rx_s <= s1;
         rx_d <= rx_s;
         timer <= (state == IDLE && fall) ? HALF : (timer == '0) ? FULL : timer - TW'(1);
         cnt <= (state == START) ? 3'd0 : (state == DATA && tick) ? cnt + 3'd1 : cnt;
         shreg <= (state == DATA && tick) ? {smp, shreg[7:1]} : shreg;
         if (stop_ok) O_DATA <= shreg;
         NrD <= stop_ok;
         FrE <= state == STOP && tick && !smp;
      end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table, corner sequences and random frames against a frame-level timing model
module tb_uart_rx;
   localparam int B = 16;
`ifdef UART_RX_MAJORITY_EN
   localparam int MAJ = 1;
`else
   localparam int MAJ = 0;
`endif
   localparam int LAT = 3 + B / 2 + 9 * B + MAJ;
   logic clk = 1'b0, rst_n = 1'b0, Rx = 1'b1;
   logic [7:0] O_DATA;
   logic NrD, RiP, FrE;
   uart_rx #(.BAUD_DIVIDER(B)) dut (
      .clk(clk), .rst_n(rst_n), .Rx(Rx), .O_DATA(O_DATA), .NrD(NrD), .RiP(RiP), .FrE(FrE)
   );
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {int t; logic nrd; logic fre; logic [7:0] d;} ev_t;
   typedef struct {logic [7:0] d; logic stop; int gap; int gb; logic [7:0] exp_d; logic exp_nrd; bit rip;} vec_t;
   ev_t got[$], exp_q[$];
   int checks = 0, errors = 0;
   logic [7:0] last_good = 8'h00;
   always @(negedge clk) if (NrD || FrE) got.push_back('{cyc, NrD, FrE, O_DATA});
   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask
   task automatic send(input logic [7:0] d, input logic stop, input int gap, gb, abort_n, input bit rip, output int st);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      st = 0;
      for (int n = 0; n < (10 + gap) * B; n++) begin
         @(negedge clk);
         if (n == 0) st = cyc;
         if (n == abort_n) return;
         if (rip && n < 10 * B) chk($sformatf("rip@%0d", n), RiP, n >= 3 && n < LAT);
         Rx = (n / B >= 10) ? 1'b1 : (gb >= 0 && n / B == gb + 1 && n % B == B / 2) ? 1'b1 : fr[n / B];
      end
   endtask
   task automatic model(input int st, input logic [7:0] d, input logic stop, input int gb);
      logic [7:0] v;
      v = (gb >= 0 && MAJ == 0) ? d | (8'h01 << gb) : d;
      if (stop) last_good = v;
      exp_q.push_back('{st + LAT, stop, !stop, last_good});
   endtask
   task automatic drain(input string nm);
      chk({nm, " count"}, got.size(), exp_q.size());
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s[%0d] time", nm, i), got[i].t, exp_q[i].t);
         chk($sformatf("%s[%0d] nrd", nm, i), got[i].nrd, exp_q[i].nrd);
         chk($sformatf("%s[%0d] fre", nm, i), got[i].fre, exp_q[i].fre);
         chk($sformatf("%s[%0d] data", nm, i), got[i].d, exp_q[i].d);
      end
      got.delete();
      exp_q.delete();
   endtask
   initial begin
      vec_t tv[4];
      int st;
      logic [7:0] d;
      logic stop;
      tv = '{'{8'h55, 1'b1, 1, -1, 8'h55, 1'b1, 1'b1},
             '{8'hA5, 1'b1, 0, -1, 8'hA5, 1'b1, 1'b0},
             '{8'h3C, 1'b1, 1, -1, 8'h3C, 1'b1, 1'b0},
             '{8'h00, 1'b1, 1, 2, (MAJ != 0) ? 8'h00 : 8'h04, 1'b1, 1'b0}};
      repeat (3) @(negedge clk);
      chk("reset O_DATA", O_DATA, 8'h00);
      chk("reset NrD", NrD, 0);
      chk("reset RiP", RiP, 0);
      chk("reset FrE", FrE, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         send(tv[i].d, tv[i].stop, tv[i].gap, tv[i].gb, -1, tv[i].rip, st);
         exp_q.push_back('{st + LAT, tv[i].exp_nrd, !tv[i].exp_nrd, tv[i].exp_d});
         last_good = tv[i].exp_d;
      end
      repeat (B) @(negedge clk);
      drain("table");
      @(negedge clk);
      Rx = 1'b0;
      repeat (4) @(negedge clk);
      chk("false start RiP high", RiP, 1);
      repeat (2) @(negedge clk);
      Rx = 1'b1;
      repeat (2 * B) @(negedge clk);
      chk("false start RiP low", RiP, 0);
      chk("false start O_DATA", O_DATA, last_good);
      drain("false start");
      send(8'hF0, 1'b0, 0, -1, -1, 1'b0, st);
      model(st, 8'hF0, 1'b0, -1);
      Rx = 1'b0;
      for (int n = 0; n < 40 * B; n++) begin
         @(negedge clk);
         if (n == 20 * B) chk("break RiP", RiP, 1);
      end
      Rx = 1'b1;
      repeat (B) @(negedge clk);
      chk("break O_DATA", O_DATA, last_good);
      drain("break");
      send(8'h81, 1'b1, 1, -1, -1, 1'b0, st);
      model(st, 8'h81, 1'b1, -1);
      repeat (B) @(negedge clk);
      drain("after break");
      send(8'h77, 1'b1, 1, -1, 5 * B + 8, 1'b0, st);
      rst_n = 1'b0;
      Rx = 1'b1;
      #1;
      chk("midframe reset O_DATA", O_DATA, 8'h00);
      chk("midframe reset RiP", RiP, 0);
      chk("midframe reset NrD", NrD, 0);
      last_good = 8'h00;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (20 * B) @(negedge clk);
      chk("post reset O_DATA", O_DATA, 8'h00);
      drain("aborted");
      send(8'h12, 1'b1, 1, -1, -1, 1'b0, st);
      model(st, 8'h12, 1'b1, -1);
      repeat (B) @(negedge clk);
      drain("after reset");
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         stop = $urandom_range(0, 4) != 0;
         send(d, stop, -1, -1, -1, 1'b0, st) ;
      end
      repeat (2) @(negedge clk);
      got.delete();
      exp_q.delete();
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom);
         stop = $urandom_range(0, 4) != 0;
         send(d, stop, stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)), -1, -1, 1'b0, st);
         model(st, d, stop, -1);
      end
      repeat (2 * B) @(negedge clk);
      drain("random");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
